// File: rtl/linebuf_pixel_fetch.sv
// Line-buffer read side: fetches 16-bit words from the line BRAM, serialises them
// into 2-bit pixel codes (MSB pair first) and drives registered 4:4:4 RGB through a palette.
module linebuf_pixel_fetch #(
  parameter int          WORDS_PER_LINE = 100,
  parameter logic [11:0] COLOR0         = 12'h000,
  parameter logic [11:0] COLOR1         = 12'hFF0,
  parameter logic [11:0] COLOR2         = 12'h208,
  parameter logic [11:0] COLOR3         = 12'hFFF
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        pix_tick,
  input  logic        line_start,
  input  logic [7:0]  line_base,
  input  logic        vis,
  output logic        lb_rd,
  output logic [7:0]  lb_rd_addr,
  input  logic [15:0] lb_rd_data,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        underrun
);

  localparam int CNT_W = $clog2(WORDS_PER_LINE + 1);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P0W,
    P1W,
    ACTIVE
  } state_t;

  typedef enum logic [2:0] {
    PX_HOLD,
    PX_BLANK,
    PX_UNDERRUN,
    PX_SHIFT,
    PX_LOAD_NEXT,
    PX_LOAD_ZERO
  } px_act_t;

  state_t             state;
  state_t             state_next;
  px_act_t            px_act;

  logic               rd_valid;
  logic [15:0]        shift_reg;
  logic [15:0]        next_word;
  logic               next_valid;
  logic [2:0]         pixcnt;
  logic [CNT_W-1:0]   fetch_cnt;
  logic [11:0]        rgb;

  logic               ready;
  logic               more_words;
  logic               exhausted;
  logic               issue_rd;
  logic [7:0]         issue_addr;
  logic               load_shift;
  logic               load_next;

  function automatic logic [11:0] palette(input logic [1:0] code);
    case (code)
      2'b00:   return COLOR0;
      2'b01:   return COLOR1;
      2'b10:   return COLOR2;
      default: return COLOR3;
    endcase
  endfunction

  // Pixels may be drawn as soon as word 0 sits in the shift register; word 1 is
  // still landing in P1W but is not needed until the eighth pixel.
  assign ready      = (state == P1W) || (state == ACTIVE);
  assign more_words = fetch_cnt < CNT_W'(WORDS_PER_LINE);
  assign exhausted  = !more_words && !next_valid && !lb_rd && !rd_valid;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_next = state;
    issue_rd   = 1'b0;
    issue_addr = lb_rd_addr + 8'd1;
    load_shift = 1'b0;
    load_next  = 1'b0;
    px_act     = PX_HOLD;

    if (line_start) begin
      state_next = P0;
      issue_rd   = 1'b1;
      issue_addr = line_base;
      if (pix_tick) px_act = vis ? PX_UNDERRUN : PX_BLANK;
    end else begin
      case (state)
        IDLE: ;
        P0:   state_next = P0W;
        P0W: begin
          if (rd_valid) begin
            load_shift = 1'b1;
            if (more_words) begin
              issue_rd   = 1'b1;
              state_next = P1W;
            end else begin
              state_next = ACTIVE;
            end
          end
        end
        P1W: begin
          if (rd_valid) begin
            load_next  = 1'b1;
            state_next = ACTIVE;
          end
        end
        ACTIVE:  if (rd_valid) load_next = 1'b1;
        default: state_next = IDLE;
      endcase

      if (pix_tick) begin
        if (!vis)                px_act = PX_BLANK;
        else if (!ready)         px_act = PX_UNDERRUN;
        else if (pixcnt != 3'd7) px_act = PX_SHIFT;
        else if (next_valid) begin
          px_act   = PX_LOAD_NEXT;
          issue_rd = more_words;
        end
        else if (exhausted)      px_act = PX_LOAD_ZERO;
        else                     px_act = PX_UNDERRUN;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (nrst) state <= IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      lb_rd      <= 1'b0;
      lb_rd_addr <= 8'd0;
      rd_valid   <= 1'b0;
      shift_reg  <= 16'd0;
      next_word  <= 16'd0;
      next_valid <= 1'b0;
      pixcnt     <= 3'd0;
      fetch_cnt  <= '0;
      rgb        <= 12'd0;
      underrun   <= 1'b0;
    end else begin
      lb_rd <= issue_rd;
      if (issue_rd) lb_rd_addr <= issue_addr;
      // A read in flight across line_start is dropped by never flagging its data valid.
      rd_valid <= lb_rd && !line_start;

      if (line_start)    fetch_cnt <= CNT_W'(1);
      else if (issue_rd) fetch_cnt <= fetch_cnt + CNT_W'(1);

      if (line_start) begin
        pixcnt     <= 3'd0;
        next_valid <= 1'b0;
      end

      case (px_act)
        PX_BLANK: rgb <= 12'd0;
        PX_UNDERRUN: begin
          rgb      <= 12'd0;
          underrun <= 1'b1;
        end
        PX_SHIFT: begin
          rgb       <= palette(shift_reg[15:14]);
          shift_reg <= {shift_reg[13:0], 2'b00};
          pixcnt    <= pixcnt + 3'd1;
        end
        PX_LOAD_NEXT: begin
          rgb        <= palette(shift_reg[15:14]);
          shift_reg  <= next_word;
          next_valid <= 1'b0;
          pixcnt     <= pixcnt + 3'd1;
        end
        PX_LOAD_ZERO: begin
          rgb       <= palette(shift_reg[15:14]);
          shift_reg <= 16'd0;
          pixcnt    <= pixcnt + 3'd1;
        end
        default: ;
      endcase

      if (load_shift) shift_reg <= lb_rd_data;
      if (load_next) begin
        next_word  <= lb_rd_data;
        next_valid <= 1'b1;
      end
    end
  end

  assign red   = rgb[11:8];
  assign green = rgb[7:4];
  assign blue  = rgb[3:0];

endmodule

// File: tb/tb_linebuf_pixel_fetch.sv
// Self-checking bench for linebuf_pixel_fetch: a BRAM model answers reads, and a
// reference computes each visible pixel directly from line_base and the pixel index.
module tb_linebuf_pixel_fetch;

  localparam int WPL      = 100;
  localparam int LINE_PIX = WPL * 8;
  localparam logic [11:0] PAL [4] = '{12'h000, 12'hFF0, 12'h208, 12'hFFF};

  logic        clk = 1'b0;
  logic        nrst;
  logic        pix_tick;
  logic        line_start;
  logic [7:0]  line_base;
  logic        vis;
  logic        lb_rd;
  logic [7:0]  lb_rd_addr;
  logic [15:0] lb_rd_data;
  logic [3:0]  red;
  logic [3:0]  green;
  logic [3:0]  blue;
  logic        underrun;

  always #5 clk = ~clk;

  linebuf_pixel_fetch dut (
    .clk        (clk),
    .nrst       (nrst),
    .pix_tick   (pix_tick),
    .line_start (line_start),
    .line_base  (line_base),
    .vis        (vis),
    .lb_rd      (lb_rd),
    .lb_rd_addr (lb_rd_addr),
    .lb_rd_data (lb_rd_data),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .underrun   (underrun)
  );

  // BRAM model: data for a read is presented only in the cycle after lb_rd; garbage otherwise.
  logic [15:0] mem [256];
  logic [7:0]  rd_log [$];
  logic        rd_q;
  logic [7:0]  rd_addr_q;

  always @(posedge clk) begin
    if (lb_rd === 1'b1) rd_log.push_back(lb_rd_addr);
    rd_q      = (lb_rd === 1'b1);
    rd_addr_q = lb_rd_addr;
    #1;
    lb_rd_data = rd_q ? mem[rd_addr_q] : 16'($urandom);
  end

  int          n_checks;
  int          n_errors;
  logic [7:0]  m_base;
  int          m_n;
  logic        m_under;
  logic [11:0] exp_rgb;

  typedef struct {
    logic        vis;
    int          rep;
    logic [11:0] rgb;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pixel(input int n);
    logic [15:0] w;
    logic [1:0]  code;
    int          a;
    if (n >= LINE_PIX) return PAL[0];
    a    = (int'(m_base) + n / 8) % 256;
    w    = mem[a];
    code = 2'((w >> (14 - 2 * (n % 8))) & 16'h3);
    return PAL[code];
  endfunction

  // One clock: drive inputs, pass the edge, then advance the reference.
  task automatic cyc(input logic ls, input logic pt, input logic v);
    line_start = ls;
    pix_tick   = pt;
    vis        = v;
    @(posedge clk);
    #1;
    line_start = 1'b0;
    pix_tick   = 1'b0;
    vis        = 1'b0;
    if (ls) begin
      rd_log.delete();
      m_base = line_base;
      m_n    = 0;
      if (pt) begin
        exp_rgb = 12'h000;
        if (v) m_under = 1'b1;
      end
    end else if (pt) begin
      if (v) begin
        exp_rgb = ref_pixel(m_n);
        m_n++;
      end else begin
        exp_rgb = 12'h000;
      end
    end
  endtask

  task automatic pix(input logic v, input int gap);
    cyc(1'b0, 1'b1, v);
    check("rgb", 32'({red, green, blue}), 32'(exp_rgb));
    repeat (gap - 1) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic start_line(input logic [7:0] base, input int lead);
    line_base = base;
    cyc(1'b1, 1'b0, 1'b0);
    repeat (lead - 1) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to(input int target, input int gap_max, input int vis_pct);
    while (m_n < target)
      pix(logic'(int'($urandom_range(99, 0)) < vis_pct), int'($urandom_range(gap_max, 2)));
  endtask

  task automatic check_reads(input logic [7:0] base);
    check("rd_count", 32'(rd_log.size()), 32'(WPL));
    for (int i = 0; i < rd_log.size() && i < WPL; i++)
      check("rd_addr", 32'(rd_log[i]), 32'((int'(base) + i) % 256));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    m_base     = 8'd0;
    m_n        = 0;
    m_under    = 1'b0;
    exp_rgb    = 12'h000;
    lb_rd_data = 16'd0;
    pix_tick   = 1'b0;
    vis        = 1'b0;
    line_base  = 8'd0;
    for (int a = 0; a < 256; a++) mem[a] = 16'h1B1B;

    vecs = '{
      '{1'b1, 1,  12'h000}, '{1'b1, 1, 12'hFF0}, '{1'b1, 1, 12'h208},
      '{1'b0, 10, 12'h000}, '{1'b1, 1, 12'hFFF}, '{1'b1, 1, 12'h000},
      '{1'b1, 1,  12'hFF0}, '{1'b0, 1, 12'h000}, '{1'b1, 1, 12'h208},
      '{1'b1, 1,  12'hFFF}, '{1'b1, 1, 12'h000}, '{1'b1, 1, 12'hFF0}
    };

    // T1: reset held 3 clk with line_start asserted throughout
    nrst       = 1'b1;
    line_start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    line_start = 1'b0;
    check("rst_rgb", 32'({red, green, blue}), 32'h0);
    check("rst_lb_rd", 32'(lb_rd), 32'h0);
    check("rst_addr", 32'(lb_rd_addr), 32'h0);
    check("rst_underrun", 32'(underrun), 32'h0);
    nrst = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b0);
    check("rst_no_reads", 32'(rd_log.size()), 32'h0);

    // T2/T3: decode table with a blanking gap mid-word, then the rest of the line
    start_line(8'h00, 4);
    for (int i = 0; i < 12; i++) begin
      for (int r = 0; r < vecs[i].rep; r++) begin
        cyc(1'b0, 1'b1, vecs[i].vis);
        check("vec_rgb", 32'({red, green, blue}), 32'(vecs[i].rgb));
        cyc(1'b0, 1'b0, 1'b0);
      end
    end
    run_to(LINE_PIX, 2, 100);
    check_reads(8'h00);
    check("t2_underrun", 32'(underrun), 32'h0);

    // T6: visible pixels past the end of the line
    for (int i = 0; i < 10; i++) begin
      pix(1'b1, 2);
      check("eol_rgb", 32'({red, green, blue}), 32'h000);
    end
    check("eol_no_reads", 32'(rd_log.size()), 32'(WPL));
    check("eol_underrun", 32'(underrun), 32'h0);

    // Simultaneous line_start and pix_tick with vis=0: blank pixel, no underrun
    start_line(8'h00, 4);
    pix(1'b1, 2);
    pix(1'b1, 2);
    cyc(1'b1, 1'b1, 1'b0);
    check("ls_pt_rgb", 32'({red, green, blue}), 32'h000);
    check("ls_pt_underrun", 32'(underrun), 32'h0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0);
    pix(1'b1, 2);
    pix(1'b1, 2);

    // T4: visible pixel one clk after line_start
    line_base  = 8'h00;
    cyc(1'b1, 1'b0, 1'b0);
    pix_tick   = 1'b1;
    vis        = 1'b1;
    @(posedge clk);
    #1;
    pix_tick   = 1'b0;
    vis        = 1'b0;
    check("t4_rgb", 32'({red, green, blue}), 32'h000);
    check("t4_underrun", 32'(underrun), 32'h1);
    repeat (20) cyc(1'b0, 1'b0, 1'b0);
    check("t4_sticky", 32'(underrun), 32'h1);

    // Reset right after a read was issued
    line_base = 8'h40;
    cyc(1'b1, 1'b0, 1'b0);
    nrst = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0);
    check("rst2_lb_rd", 32'(lb_rd), 32'h0);
    check("rst2_addr", 32'(lb_rd_addr), 32'h0);
    check("rst2_underrun", 32'(underrun), 32'h0);
    check("rst2_rgb", 32'({red, green, blue}), 32'h000);
    nrst    = 1'b0;
    m_under = 1'b0;
    repeat (6) cyc(1'b0, 1'b0, 1'b0);
    check("rst2_reads", 32'(rd_log.size()), 32'h1);

    // T5: random data, mid-line restart at F8 (address wrap), then random lines
    for (int a = 0; a < 256; a++) mem[a] = 16'($urandom);
    start_line(8'($urandom), int'($urandom_range(6, 4)));
    run_to(int'($urandom_range(500, 50)), 3, 85);
    start_line(8'hF8, 4);
    run_to(LINE_PIX + 6, 4, 85);
    check_reads(8'hF8);
    check("t5_underrun", 32'(underrun), 32'(m_under));

    for (int l = 0; l < 2; l++) begin
      start_line(8'($urandom), int'($urandom_range(6, 4)));
      run_to(LINE_PIX + 4, 4, 85);
      check_reads(m_base);
      check("rand_underrun", 32'(underrun), 32'(m_under));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
